// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite encodings shared by masters, slaves and the request bridge.
package ahb3lite_pkg;

    localparam int unsigned HTRANS_W = 2;
    localparam int unsigned HSIZE_W  = 3;
    localparam int unsigned HBURST_W = 3;
    localparam int unsigned HPROT_W  = 4;

    localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [HSIZE_W-1:0] HSIZE_BYTE  = 3'b000;
    localparam logic [HSIZE_W-1:0] HSIZE_HWORD = 3'b001;
    localparam logic [HSIZE_W-1:0] HSIZE_WORD  = 3'b010;
    localparam logic [HSIZE_W-1:0] HSIZE_DWORD = 3'b011;
    localparam logic [HSIZE_W-1:0] HSIZE_B128  = 3'b100;
    localparam logic [HSIZE_W-1:0] HSIZE_B256  = 3'b101;
    localparam logic [HSIZE_W-1:0] HSIZE_B512  = 3'b110;
    localparam logic [HSIZE_W-1:0] HSIZE_B1024 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [HBURST_W-1:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/ahb3lite_req2ahb.sv
// Request-stream to AHB3-Lite master bridge: one SINGLE transfer per request,
// address phase of the next transfer overlapped with the current data phase,
// in-order responses, two-cycle ERROR handling and local misalignment errors.
//
// Ports:
//   HRESETn, HCLK         async active-low reset, rising-edge clock
//   req_*                 valid/ready request stream (req_ready_o is combinational)
//   rsp_*                 one-cycle response strobe with read data and error flag
//   H*                    AHB3-Lite master interface
module ahb3lite_req2ahb
    import ahb3lite_pkg::*;
#(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [HADDR_SIZE-1:0] req_addr_i,
    input  logic [2:0]            req_size_i,
    input  logic [HDATA_SIZE-1:0] req_wdata_i,

    output logic                  rsp_valid_o,
    output logic [HDATA_SIZE-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,

    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,

    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    // Address not aligned to the transfer size, or transfer wider than the bus.
    function automatic logic misaligned(input logic [HADDR_SIZE-1:0] addr,
                                        input logic [2:0]            size);
        logic [HADDR_SIZE-1:0] mask;
        logic [31:0]           bits;
        mask = HADDR_SIZE'((32'd1 << size) - 32'd1);
        bits = 32'd8 << size;
        return ((addr & mask) != '0) || (bits > 32'(HDATA_SIZE));
    endfunction

    // Address-phase stage
    logic                  aph_valid, aph_valid_nxt;
    logic [HADDR_SIZE-1:0] aph_addr,  aph_addr_nxt;
    logic                  aph_write, aph_write_nxt;
    logic [2:0]            aph_size,  aph_size_nxt;
    logic [HDATA_SIZE-1:0] aph_wdata, aph_wdata_nxt;
    logic                  aph_mis,   aph_mis_nxt;

    // Data-phase stage
    logic                  dph_valid, dph_valid_nxt;
    logic                  dph_write, dph_write_nxt;
    logic [HDATA_SIZE-1:0] dph_wdata, dph_wdata_nxt;
    logic                  dph_mis,   dph_mis_nxt;

    // Second cycle of an ERROR response suppresses the pending address phase
    logic                  idle_ovr,  idle_ovr_nxt;

    logic [1:0]            htrans,    htrans_nxt;
    logic                  rsp_valid, rsp_valid_nxt;
    logic                  rsp_err,   rsp_err_nxt;
    logic [HDATA_SIZE-1:0] rsp_rdata, rsp_rdata_nxt;

    logic addr_adv_c;
    logic accept_c;
    logic dph_done_c;

    assign req_ready_o = ~aph_valid | (HREADY & ~idle_ovr);

    assign addr_adv_c  = aph_valid & HREADY & ~idle_ovr;
    assign accept_c    = req_valid_i & req_ready_o;
    assign dph_done_c  = dph_valid & HREADY;

    // Next-state for both pipeline stages, the error override and the response
    always_comb begin
        aph_valid_nxt = aph_valid;
        aph_addr_nxt  = aph_addr;
        aph_write_nxt = aph_write;
        aph_size_nxt  = aph_size;
        aph_wdata_nxt = aph_wdata;
        aph_mis_nxt   = aph_mis;
        dph_valid_nxt = dph_valid;
        dph_write_nxt = dph_write;
        dph_wdata_nxt = dph_wdata;
        dph_mis_nxt   = dph_mis;
        idle_ovr_nxt  = idle_ovr;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        htrans_nxt    = HTRANS_IDLE;

        // Misaligned entries travel through dph as well so responses stay ordered
        if (addr_adv_c) begin
            dph_valid_nxt = 1'b1;
            dph_write_nxt = aph_write;
            dph_wdata_nxt = aph_wdata;
            dph_mis_nxt   = aph_mis;
        end else if (HREADY) begin
            dph_valid_nxt = 1'b0;
        end

        // A new request may refill aph in the same cycle it advances
        if (accept_c) begin
            aph_valid_nxt = 1'b1;
            aph_addr_nxt  = req_addr_i;
            aph_write_nxt = req_write_i;
            aph_size_nxt  = req_size_i;
            aph_wdata_nxt = req_wdata_i;
            aph_mis_nxt   = misaligned(req_addr_i, req_size_i);
        end else if (addr_adv_c) begin
            aph_valid_nxt = 1'b0;
        end

        if (dph_done_c) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = dph_mis | (HRESP == HRESP_ERROR);
            if (!dph_write) begin
                rsp_rdata_nxt = HRDATA;
            end
        end

        // Only the first (HREADY=0) ERROR cycle arms the override
        if (HREADY) begin
            idle_ovr_nxt = 1'b0;
        end else if (dph_valid && (HRESP == HRESP_ERROR)) begin
            idle_ovr_nxt = 1'b1;
        end

        if (aph_valid_nxt && !aph_mis_nxt && !idle_ovr_nxt) begin
            htrans_nxt = HTRANS_NONSEQ;
        end
    end

    // Pipeline and response registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            aph_valid <= 1'b0;
            aph_addr  <= '0;
            aph_write <= 1'b0;
            aph_size  <= 3'd0;
            aph_wdata <= '0;
            aph_mis   <= 1'b0;
            dph_valid <= 1'b0;
            dph_write <= 1'b0;
            dph_wdata <= '0;
            dph_mis   <= 1'b0;
            idle_ovr  <= 1'b0;
            htrans    <= HTRANS_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            aph_valid <= aph_valid_nxt;
            aph_addr  <= aph_addr_nxt;
            aph_write <= aph_write_nxt;
            aph_size  <= aph_size_nxt;
            aph_wdata <= aph_wdata_nxt;
            aph_mis   <= aph_mis_nxt;
            dph_valid <= dph_valid_nxt;
            dph_write <= dph_write_nxt;
            dph_wdata <= dph_wdata_nxt;
            dph_mis   <= dph_mis_nxt;
            idle_ovr  <= idle_ovr_nxt;
            htrans    <= htrans_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

    assign HADDR       = aph_addr;
    assign HWRITE      = aph_write;
    assign HSIZE       = aph_size;
    assign HTRANS      = htrans;
    assign HWDATA      = dph_wdata;
    assign HBURST      = HBURST_SINGLE;
    assign HPROT       = HPROT_VAL;
    assign HMASTLOCK   = 1'b0;

    assign rsp_valid_o = rsp_valid;
    assign rsp_err_o   = rsp_err;
    assign rsp_rdata_o = rsp_rdata;

endmodule

// File: tb/tb_ahb3lite_req2ahb.sv
// Bench for ahb3lite_req2ahb: behavioural AHB slave with programmable wait
// states and ERROR address, a request table run back-to-back, and directed
// sequences for latency, wait states, ERROR, misalignment and reset.
module tb_ahb3lite_req2ahb;
    import ahb3lite_pkg::*;

    logic        HRESETn;
    logic        HCLK;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [2:0]  req_size_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb3lite_req2ahb #(
        .HADDR_SIZE (32),
        .HDATA_SIZE (32),
        .HPROT_VAL  (4'b0011)
    ) dut (
        .HRESETn     (HRESETn),
        .HCLK        (HCLK),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_size_i  (req_size_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .HADDR       (HADDR),
        .HWDATA      (HWDATA),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HTRANS      (HTRANS),
        .HMASTLOCK   (HMASTLOCK),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        write;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   rsp_cycles[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural AHB slave ----------------
    logic [31:0] mem [0:255];
    logic        m_act;
    logic        m_write;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    int          m_wcnt;
    int          m_err;
    logic [31:0] wait_addr = 32'hFFFF_FFF0;
    logic [31:0] err_addr  = 32'hFFFF_FFF0;
    int          wait_n    = 0;
    int          xfer_cnt  = 0;

    function automatic logic lane_en(input logic [31:0] a, input logic [2:0] s, input int b);
        if (s >= 3'd2) return 1'b1;
        if (s == 3'd1) return (b / 2) == int'(a[1]);
        return b == int'(a[1:0]);
    endfunction

    assign HREADY = !m_act || ((m_err == 0) ? (m_wcnt == 0) : (m_err == 2));
    assign HRESP  = m_act && (m_err != 0);
    assign HRDATA = (m_act && !m_write) ? mem[m_addr[9:2]] : 32'h0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_act   <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= 32'h0;
            m_size  <= 3'd0;
            m_wcnt  <= 0;
            m_err   <= 0;
        end else if (!HREADY) begin
            if (m_err == 1) m_err <= 2;
            else if (m_wcnt > 0) m_wcnt <= m_wcnt - 1;
        end else begin
            if (m_act && m_write && m_err == 0) begin
                for (int b = 0; b < 4; b++) begin
                    if (lane_en(m_addr, m_size, b)) mem[m_addr[9:2]][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
            if (HTRANS == HTRANS_NONSEQ) begin
                m_act    <= 1'b1;
                m_write  <= HWRITE;
                m_addr   <= HADDR;
                m_size   <= HSIZE;
                m_err    <= (HADDR == err_addr) ? 1 : 0;
                m_wcnt   <= (HADDR == wait_addr) ? wait_n : 0;
                xfer_cnt <= xfer_cnt + 1;
            end else begin
                m_act <= 1'b0;
                m_err <= 0;
            end
        end
    end

    // ---------------- response monitor ----------------
    always @(posedge HCLK) cycle <= cycle + 1;

    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid_o) begin
            rsp_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_err", 32'(rsp_err_o), 32'(e.err));
                if (!e.write && !e.err) check("rsp_rdata", rsp_rdata_o, e.rdata);
            end
        end
    end

    // ---------------- request helpers ----------------
    task automatic drive_req(input vec_t v);
        exp_t e;
        req_valid_i = 1'b1;
        req_write_i = v.write;
        req_addr_i  = v.addr;
        req_size_i  = v.size;
        req_wdata_i = v.wdata;
        e.write = v.write;
        e.err   = v.exp_err;
        e.rdata = v.exp_rdata;
        exp_q.push_back(e);
    endtask

    task automatic issue(input vec_t v, output int stalls);
        @(negedge HCLK);
        stalls = 0;
        while (!req_ready_o && stalls < 50) begin
            @(negedge HCLK);
            stalls++;
        end
        if (stalls >= 50) check("accept_timeout", 32'(req_ready_o), 32'd1);
        drive_req(v);
    endtask

    task automatic idle_req();
        @(negedge HCLK);
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge HCLK);
            t++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    vec_t tbl [16];
    int   stalls;
    int   x0;

    initial begin
        tbl[0]  = '{1'b1, 32'h00, HSIZE_WORD,  32'h1111_1111, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h04, HSIZE_WORD,  32'h2222_2222, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h00, HSIZE_WORD,  32'h0,         1'b0, 32'h1111_1111};
        tbl[3]  = '{1'b0, 32'h04, HSIZE_WORD,  32'h0,         1'b0, 32'h2222_2222};
        tbl[4]  = '{1'b1, 32'h05, HSIZE_BYTE,  32'h0000_AB00, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 32'h04, HSIZE_WORD,  32'h0,         1'b0, 32'h2222_AB22};
        tbl[6]  = '{1'b0, 32'h00, HSIZE_WORD,  32'h0,         1'b0, 32'h1111_1111};
        tbl[7]  = '{1'b0, 32'h02, HSIZE_WORD,  32'h0,         1'b1, 32'h0};
        tbl[8]  = '{1'b0, 32'h04, HSIZE_WORD,  32'h0,         1'b0, 32'h2222_AB22};
        tbl[9]  = '{1'b1, 32'h06, HSIZE_HWORD, 32'hBEEF_0000, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 32'h04, HSIZE_WORD,  32'h0,         1'b0, 32'hBEEF_AB22};
        tbl[11] = '{1'b0, 32'h05, HSIZE_HWORD, 32'h0,         1'b1, 32'h0};
        tbl[12] = '{1'b0, 32'h08, HSIZE_DWORD, 32'h0,         1'b1, 32'h0};
        tbl[13] = '{1'b1, 32'h10, HSIZE_WORD,  32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 32'h20, HSIZE_WORD,  32'hCAFE_F00D, 1'b0, 32'h0};
        tbl[15] = '{1'b1, 32'h24, HSIZE_WORD,  32'h2424_2424, 1'b0, 32'h0};

        HRESETn     = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = 32'h0;
        req_size_i  = 3'd0;
        req_wdata_i = 32'h0;
        repeat (3) @(negedge HCLK);

        // Reset state
        check("rst_htrans",    32'(HTRANS), 32'(HTRANS_IDLE));
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_err",   32'(rsp_err_o), 32'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        check("rst_haddr",     HADDR, 32'd0);
        check("rst_hwdata",    HWDATA, 32'd0);
        check("rst_ready",     32'(req_ready_o), 32'd1);
        check("rst_hburst",    32'(HBURST), 32'd0);
        check("rst_hprot",     32'(HPROT), 32'h3);
        check("rst_hmastlock", 32'(HMASTLOCK), 32'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Table run, req_valid_i held high throughout
        rsp_cycles.delete();
        x0 = xfer_cnt;
        for (int i = 0; i < 16; i++) begin
            issue(tbl[i], stalls);
            check($sformatf("b2b_stall_%0d", i), 32'(stalls), 32'd0);
        end
        idle_req();
        drain();
        check("b2b_rsp_count", 32'(rsp_cycles.size()), 32'd16);
        for (int i = 1; i < rsp_cycles.size() && i < 16; i++)
            check($sformatf("b2b_rsp_gap_%0d", i), 32'(rsp_cycles[i] - rsp_cycles[i-1]), 32'd1);
        check("mis_no_bus_xfer", 32'(xfer_cnt - x0), 32'd13);

        // Zero-wait read latency
        @(negedge HCLK);
        check("lat_ready", 32'(req_ready_o), 32'd1);
        drive_req('{1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 32'hDEAD_BEEF});
        @(negedge HCLK);
        check("lat_c1_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        check("lat_c1_haddr",  HADDR, 32'h10);
        check("lat_c1_hwrite", 32'(HWRITE), 32'd0);
        check("lat_c1_hsize",  32'(HSIZE), 32'(HSIZE_WORD));
        req_valid_i = 1'b0;
        @(negedge HCLK);
        check("lat_c2_rsp",    32'(rsp_valid_o), 32'd0);
        check("lat_c2_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        @(negedge HCLK);
        check("lat_c3_rsp",    32'(rsp_valid_o), 32'd1);
        drain();

        // Wait states on the read of 0x20 while 0x24 waits in aph
        wait_addr = 32'h20;
        wait_n    = 3;
        @(negedge HCLK);
        drive_req('{1'b0, 32'h20, HSIZE_WORD, 32'h0, 1'b0, 32'hCAFE_F00D});
        @(negedge HCLK);
        check("ws_c1_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        check("ws_c1_haddr",  HADDR, 32'h20);
        check("ws_c1_ready",  32'(req_ready_o), 32'd1);
        drive_req('{1'b0, 32'h24, HSIZE_WORD, 32'h0, 1'b0, 32'h2424_2424});
        @(negedge HCLK);
        req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ws_hready",  32'(HREADY), 32'd0);
            check("ws_htrans",  32'(HTRANS), 32'(HTRANS_NONSEQ));
            check("ws_haddr",   HADDR, 32'h24);
            check("ws_ready",   32'(req_ready_o), 32'd0);
            check("ws_rsp",     32'(rsp_valid_o), 32'd0);
            @(negedge HCLK);
        end
        check("ws_c5_hready", 32'(HREADY), 32'd1);
        check("ws_c5_rsp",    32'(rsp_valid_o), 32'd0);
        @(negedge HCLK);
        check("ws_c6_rsp",    32'(rsp_valid_o), 32'd1);
        @(negedge HCLK);
        check("ws_c7_rsp",    32'(rsp_valid_o), 32'd1);
        @(negedge HCLK);
        check("ws_c8_rsp",    32'(rsp_valid_o), 32'd0);
        drain();
        wait_addr = 32'hFFFF_FFF0;
        wait_n    = 0;

        // Two-cycle ERROR on 0x100 with a write to 0x104 pending
        err_addr = 32'h100;
        @(negedge HCLK);
        drive_req('{1'b0, 32'h100, HSIZE_WORD, 32'h0, 1'b1, 32'h0});
        @(negedge HCLK);
        check("err_c1_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        check("err_c1_haddr",  HADDR, 32'h100);
        drive_req('{1'b1, 32'h104, HSIZE_WORD, 32'h5A5A_5A5A, 1'b0, 32'h0});
        @(negedge HCLK);
        req_valid_i = 1'b0;
        check("err_c2_hresp",  32'(HRESP), 32'd1);
        check("err_c2_hready", 32'(HREADY), 32'd0);
        check("err_c2_haddr",  HADDR, 32'h104);
        @(negedge HCLK);
        check("err_c3_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        check("err_c3_hready", 32'(HREADY), 32'd1);
        check("err_c3_ready",  32'(req_ready_o), 32'd0);
        check("err_c3_rsp",    32'(rsp_valid_o), 32'd0);
        @(negedge HCLK);
        check("err_c4_rsp",    32'(rsp_valid_o), 32'd1);
        check("err_c4_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        check("err_c4_haddr",  HADDR, 32'h104);
        check("err_c4_hwrite", 32'(HWRITE), 32'd1);
        @(negedge HCLK);
        check("err_c5_hwdata", HWDATA, 32'h5A5A_5A5A);
        check("err_c5_hresp",  32'(HRESP), 32'd0);
        drain();
        err_addr = 32'hFFFF_FFF0;
        issue('{1'b0, 32'h104, HSIZE_WORD, 32'h0, 1'b0, 32'h5A5A_5A5A}, stalls);
        idle_req();
        drain();

        // Misaligned request alone: no bus transfer
        @(negedge HCLK);
        x0 = xfer_cnt;
        drive_req('{1'b0, 32'h02, HSIZE_WORD, 32'h0, 1'b1, 32'h0});
        @(negedge HCLK);
        check("mis_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        check("mis_ready",  32'(req_ready_o), 32'd1);
        req_valid_i = 1'b0;
        drain();
        check("mis_xfer", 32'(xfer_cnt - x0), 32'd0);

        // Reset during a wait-stated data phase
        wait_addr = 32'h40;
        wait_n    = 10;
        @(negedge HCLK);
        drive_req('{1'b0, 32'h40, HSIZE_WORD, 32'h0, 1'b0, 32'h0});
        @(negedge HCLK);
        req_valid_i = 1'b0;
        @(negedge HCLK);
        check("rstm_hready", 32'(HREADY), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check("rstm_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        check("rstm_rsp",    32'(rsp_valid_o), 32'd0);
        check("rstm_ready",  32'(req_ready_o), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge HCLK);
        HRESETn   = 1'b1;
        wait_addr = 32'hFFFF_FFF0;
        wait_n    = 0;
        issue('{1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 32'hDEAD_BEEF}, stalls);
        idle_req();
        drain();
        repeat (4) @(negedge HCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb3lite_req2ahb.md
Name: ahb3lite_req2ahb

Overview:
- Single-outstanding-pipeline AHB3-Lite master bridge feeding ahb3lite_sram1rw and the other AHB3-Lite slaves.
- Converts a valid/ready request stream (CPU/DMA native port) into pipelined AHB3-Lite SINGLE transfers.
- Returns one in-order response per request.
- Overlaps the address phase of transfer N+1 with the data phase of transfer N; handles wait states, two-cycle ERROR responses and local misalignment errors.

Parameters:
- HADDR_SIZE, 32, address bus width.
- HDATA_SIZE, 32, data bus width (8..1024, power of 2).
- HPROT_VAL, 4'b0011, constant HPROT driven on every transfer.

Ports:
- HRESETn  in  1  asynchronous active-low reset
- HCLK  in  1  clock, rising edge
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when valid&ready at clock edge
- req_write_i  in  1  1=write, 0=read
- req_addr_i  in  HADDR_SIZE  byte address
- req_size_i  in  3  HSIZE encoding
- req_wdata_i  in  HDATA_SIZE  write data, lanes pre-positioned
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_rdata_o  out  HDATA_SIZE  read data (undefined for writes/errors)
- rsp_err_o  out  1  bus ERROR or local misalignment
- HADDR  out  HADDR_SIZE; HWDATA  out  HDATA_SIZE; HWRITE  out  1; HSIZE  out  3; HBURST  out  3 (always SINGLE); HPROT  out  4 (HPROT_VAL); HTRANS  out  2; HMASTLOCK  out  1 (always 0)
- HRDATA  in  HDATA_SIZE; HREADY  in  1; HRESP  in  1

Behaviour:
- Two registered stages: address-phase (aph_valid, addr, write, size, wdata, mis) and data-phase (dph_valid, write, wdata, mis).
- Reset: aph_valid=dph_valid=0, HTRANS=IDLE, rsp_valid_o=0, rsp_err_o=0, idle_ovr=0; HADDR/HWDATA/rsp_rdata_o 0. Reset mid-transfer drops all in-flight requests; no responses are produced for them.
- req_ready_o = ~aph_valid | (HREADY & ~idle_ovr), combinational.
- Accept at edge E0 loads aph. Cycle 1: HTRANS=NONSEQ, plus HADDR/HWRITE/HSIZE from aph.
- Misaligned request: addr & ((1<<size)-1) != 0, or (8<<size) > HDATA_SIZE. Sets mis. While aph holds a mis entry, HTRANS=IDLE. The entry still advances through the pipeline to keep response order.
- Address advance: at an edge with aph_valid & HREADY & ~idle_ovr, aph moves to dph. Otherwise dph_valid clears when HREADY=1.
- Address and control are held stable while HREADY=0. NONSEQ is never withdrawn except by the error rule below.
- HWDATA is driven from dph.wdata throughout the data phase and held during wait states.
- Completion: at an edge with dph_valid & HREADY:
  - next cycle rsp_valid_o=1;
  - rsp_rdata_o = HRDATA registered;
  - rsp_err_o = dph.mis | HRESP.
- Read latency with a zero-wait slave: accept E0, NONSEQ cycle 1, data cycle 2, rsp_valid_o in cycle 3. Throughput is one transfer per cycle.
- ERROR, first cycle (HRESP=1, HREADY=0, dph_valid): set idle_ovr at that edge.
- ERROR, second cycle: idle_ovr=1 forces HTRANS=IDLE, so the pending aph is not transferred. At the HREADY=1 edge, dph completes with rsp_err_o=1 and idle_ovr clears. The pending aph re-drives NONSEQ in the following cycle.
- HRESP=1 with HREADY=1 and no preceding first cycle is a protocol violation; it is reported as an error and idle_ovr is not set.
- Back-to-back accept: the request is accepted in the same cycle aph advances, so aph refills without a bubble.

Decomposition:
- ahb3lite_pkg already supplies HTRANS_*, HSIZE_*, HRESP_*. Add HBURST_SINGLE there if absent.
- Misalignment check is a local function. No sub-module is warranted; a single module of roughly 200 lines.

Test Plan:
- Read against ahb3lite_sram1rw preloaded with word 0x10 = 0xDEADBEEF: read addr 0x10, size WORD, accepted E0 -> NONSEQ in cycle 1, rsp_valid_o in cycle 3, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0.
- Back-to-back: writes 0x11111111@0x0 and 0x22222222@0x4, then reads of 0x0 and 0x4, with req_valid_i held high -> req_ready_o stays 1, four consecutive rsp_valid_o pulses, reads return 0x11111111 and 0x22222222. Also exercises the SRAM contention stall path: byte write at 0x4 followed immediately by a read of 0x4 must still return the updated byte.
- Wait states: slave model holds HREADY=0 for 3 cycles on a read -> HADDR/HTRANS stable, req_ready_o=0 while aph is occupied, a single response after release.
- Error: model answers read @0x100 with ERROR while a write @0x104 is pending -> HTRANS=IDLE in the second error cycle, rsp_err_o=1 for 0x100. The 0x104 write is then issued as NONSEQ and completes with err=0.
- Misaligned: read addr 0x2 size WORD, sandwiched between two good reads -> no bus transfer (HTRANS=IDLE), responses in order: ok, err, ok.
- Reset mid-transfer: assert HRESETn low during a wait-stated data phase -> HTRANS=IDLE and rsp_valid_o=0 immediately. After release, a new read completes normally.
